// File: rtl/sort_input_collector.sv
// Groups a serial valid/ready sample stream into registered 4-word blocks for the sorter.
// Optional partial-block flush with padding is enabled by defining SORT_COLLECT_FLUSH_EN.
module sort_input_collector #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
`ifdef SORT_COLLECT_FLUSH_EN
  input  logic             in_flush,
  output logic [2:0]       out_count,
`endif
  output logic [WIDTH-1:0] d1,
  output logic [WIDTH-1:0] d2,
  output logic [WIDTH-1:0] d3,
  output logic [WIDTH-1:0] d4,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] block_cnt
);

  // Handshakes: a transfer happens on a rising clk edge where valid && ready; valid never
  // depends on ready, while in_ready depends combinationally on out_ready.
  logic [1:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] c0_q, c0_d, c1_q, c1_d, c2_q, c2_d;
  logic [WIDTH-1:0] d1_q, d1_d, d2_q, d2_d, d3_q, d3_d, d4_q, d4_d;
  logic             out_valid_q, out_valid_d;
  logic [CNT_W-1:0] block_cnt_q, block_cnt_d;
  logic [WIDTH-1:0] blk0, blk1, blk2, blk3;
  logic             slot_free, in_xfer, out_xfer, emit;

`ifdef SORT_COLLECT_FLUSH_EN
  localparam logic [WIDTH-1:0] PAD = {WIDTH{1'b1}};
  logic [2:0] out_count_q, out_count_d;
  logic       flush_go;
`endif

  assign slot_free = !out_valid_q || out_ready;
  assign out_xfer  = out_valid_q && out_ready;
  assign in_xfer   = in_valid && in_ready;

`ifdef SORT_COLLECT_FLUSH_EN
  // A pending flush blocks input so the flushed sample cannot slip into the next block.
  assign in_ready = in_flush ? slot_free : ((cnt_q != 2'd3) || slot_free);
  assign flush_go = in_flush && slot_free && ((cnt_q != 2'd0) || in_valid);
  assign emit     = (in_xfer && (cnt_q == 2'd3)) || flush_go;
  // Slot k holds a stored sample, the sample arriving now, or padding.
  assign blk0 = (cnt_q > 2'd0) ? c0_q : ((in_xfer && cnt_q == 2'd0) ? in_data : PAD);
  assign blk1 = (cnt_q > 2'd1) ? c1_q : ((in_xfer && cnt_q == 2'd1) ? in_data : PAD);
  assign blk2 = (cnt_q > 2'd2) ? c2_q : ((in_xfer && cnt_q == 2'd2) ? in_data : PAD);
  assign blk3 = (in_xfer && cnt_q == 2'd3) ? in_data : PAD;
`else
  assign in_ready = (cnt_q != 2'd3) || slot_free;
  assign emit     = in_xfer && (cnt_q == 2'd3);
  assign blk0 = c0_q;
  assign blk1 = c1_q;
  assign blk2 = c2_q;
  assign blk3 = in_data;
`endif

  always_comb begin
    cnt_d       = cnt_q;
    c0_d        = c0_q;
    c1_d        = c1_q;
    c2_d        = c2_q;
    d1_d        = d1_q;
    d2_d        = d2_q;
    d3_d        = d3_q;
    d4_d        = d4_q;
    out_valid_d = out_valid_q;
    block_cnt_d = block_cnt_q;
`ifdef SORT_COLLECT_FLUSH_EN
    out_count_d = out_count_q;
`endif
    if (in_xfer && !emit) begin
      case (cnt_q)
        2'd0:    c0_d = in_data;
        2'd1:    c1_d = in_data;
        default: c2_d = in_data;
      endcase
      cnt_d = cnt_q + 2'd1;
    end
    if (emit) begin
      d1_d        = blk0;
      d2_d        = blk1;
      d3_d        = blk2;
      d4_d        = blk3;
      out_valid_d = 1'b1;
      cnt_d       = 2'd0;
`ifdef SORT_COLLECT_FLUSH_EN
      out_count_d = {1'b0, cnt_q} + {2'b00, in_xfer};
`endif
    end else if (out_xfer) begin
      out_valid_d = 1'b0;
    end
    if (out_xfer) block_cnt_d = block_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= 2'd0;
      c0_q        <= '0;
      c1_q        <= '0;
      c2_q        <= '0;
      d1_q        <= '0;
      d2_q        <= '0;
      d3_q        <= '0;
      d4_q        <= '0;
      out_valid_q <= 1'b0;
      block_cnt_q <= '0;
`ifdef SORT_COLLECT_FLUSH_EN
      out_count_q <= 3'd0;
`endif
    end else begin
      cnt_q       <= cnt_d;
      c0_q        <= c0_d;
      c1_q        <= c1_d;
      c2_q        <= c2_d;
      d1_q        <= d1_d;
      d2_q        <= d2_d;
      d3_q        <= d3_d;
      d4_q        <= d4_d;
      out_valid_q <= out_valid_d;
      block_cnt_q <= block_cnt_d;
`ifdef SORT_COLLECT_FLUSH_EN
      out_count_q <= out_count_d;
`endif
    end
  end

  assign d1        = d1_q;
  assign d2        = d2_q;
  assign d3        = d3_q;
  assign d4        = d4_q;
  assign out_valid = out_valid_q;
  assign block_cnt = block_cnt_q;
`ifdef SORT_COLLECT_FLUSH_EN
  assign out_count = out_count_q;
`endif

endmodule

// File: tb/tb_sort_input_collector.sv
// Directed bench for sort_input_collector; a second instance with CNT_W=2 checks counter wrap.
// Flush checks run only when SORT_COLLECT_FLUSH_EN is defined.
module tb_sort_input_collector;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in_data;
  logic        in_valid;
  logic        out_ready;
  logic        in_ready, out_valid;
  logic [15:0] d1, d2, d3, d4;
  logic [15:0] block_cnt;
  logic        in_ready2, out_valid2;
  logic [15:0] e1, e2, e3, e4;
  logic [1:0]  block_cnt2;
`ifdef SORT_COLLECT_FLUSH_EN
  logic        in_flush;
  logic [2:0]  out_count, out_count2;
`endif

  int tests_run = 0;
  int tests_failed = 0;
  int stall_cnt = 0;

  always #5 clk = ~clk;

  sort_input_collector #(.WIDTH(16), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
`ifdef SORT_COLLECT_FLUSH_EN
    .in_flush(in_flush), .out_count(out_count),
`endif
    .d1(d1), .d2(d2), .d3(d3), .d4(d4),
    .out_valid(out_valid), .out_ready(out_ready), .block_cnt(block_cnt)
  );

  sort_input_collector #(.WIDTH(16), .CNT_W(2)) dut_w2 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready2),
`ifdef SORT_COLLECT_FLUSH_EN
    .in_flush(in_flush), .out_count(out_count2),
`endif
    .d1(e1), .d2(e2), .d3(e3), .d4(e4),
    .out_valid(out_valid2), .out_ready(out_ready), .block_cnt(block_cnt2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Offers one sample and waits (bounded) until it is accepted on a clock edge.
  task automatic send(input logic [15:0] v);
    int n;
    n = 0;
    in_data  = v;
    in_valid = 1'b1;
    #1;
    while (!in_ready && n < 50) begin
      stall_cnt++;
      n++;
      tick();
    end
    if (n >= 50) check("send_timeout", 32'd0, 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic check_block(input string tag, input logic [15:0] a, input logic [15:0] b,
                             input logic [15:0] c, input logic [15:0] d);
    check({tag, "_d1"}, {16'h0, d1}, {16'h0, a});
    check({tag, "_d2"}, {16'h0, d2}, {16'h0, b});
    check({tag, "_d3"}, {16'h0, d3}, {16'h0, c});
    check({tag, "_d4"}, {16'h0, d4}, {16'h0, d});
  endtask

  logic [1:0] wrap_exp [5];

  initial begin
    wrap_exp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    in_data = 16'h0;
    in_valid = 1'b0;
    out_ready = 1'b1;
`ifdef SORT_COLLECT_FLUSH_EN
    in_flush = 1'b0;
`endif

    // Reset state and first block
    do_reset();
    check("rst_out_valid", {31'h0, out_valid}, 32'd0);
    check("rst_block_cnt", {16'h0, block_cnt}, 32'd0);
    check_block("rst", 16'h0, 16'h0, 16'h0, 16'h0);
    check("rst_in_ready", {31'h0, in_ready}, 32'd1);
    send(16'h0010);
    send(16'h0003);
    send(16'h00FF);
    check("pre4_out_valid", {31'h0, out_valid}, 32'd0);
    send(16'h0001);
    check("b1_out_valid", {31'h0, out_valid}, 32'd1);
    check_block("b1", 16'h0010, 16'h0003, 16'h00FF, 16'h0001);
    check("b1_cnt_before", {16'h0, block_cnt}, 32'd0);
    tick();
    check("b1_cnt_after", {16'h0, block_cnt}, 32'd1);
    check("b1_drained", {31'h0, out_valid}, 32'd0);

    // Continuous stream 1..12 at full rate
    do_reset();
    stall_cnt = 0;
    for (int i = 1; i <= 12; i++) begin
      send(16'(i));
      if (i % 4 == 0) begin
        check($sformatf("stream_valid_%0d", i), {31'h0, out_valid}, 32'd1);
        check_block($sformatf("stream_%0d", i), 16'(i-3), 16'(i-2), 16'(i-1), 16'(i));
      end
    end
    check("stream_stalls", stall_cnt, 32'd0);
    tick();
    check("stream_block_cnt", {16'h0, block_cnt}, 32'd3);

    // Backpressure: 4th sample stalls while a block is held
    do_reset();
    out_ready = 1'b0;
    for (int i = 1; i <= 7; i++) send(16'(i));
    in_data = 16'd8;
    in_valid = 1'b1;
    #1;
    check("bp_in_ready_low", {31'h0, in_ready}, 32'd0);
    tick();
    tick();
    check("bp_hold_valid", {31'h0, out_valid}, 32'd1);
    check("bp_in_ready_still", {31'h0, in_ready}, 32'd0);
    check_block("bp_hold", 16'd1, 16'd2, 16'd3, 16'd4);
    out_ready = 1'b1;
    #1;
    check("bp_in_ready_high", {31'h0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    check("bp_next_valid", {31'h0, out_valid}, 32'd1);
    check_block("bp_next", 16'd5, 16'd6, 16'd7, 16'd8);
    check("bp_block_cnt1", {16'h0, block_cnt}, 32'd1);
    tick();
    check("bp_block_cnt2", {16'h0, block_cnt}, 32'd2);

    // Reset discards a partial block
    send(16'h0077);
    send(16'h0088);
    do_reset();
    check("mid_rst_valid", {31'h0, out_valid}, 32'd0);
    check("mid_rst_cnt", {16'h0, block_cnt}, 32'd0);
    send(16'h000A);
    send(16'h000B);
    send(16'h000C);
    check("post_rst_no_early", {31'h0, out_valid}, 32'd0);
    send(16'h000D);
    check("post_rst_valid", {31'h0, out_valid}, 32'd1);
    check_block("post_rst", 16'h000A, 16'h000B, 16'h000C, 16'h000D);

    // Counter wrap on the CNT_W=2 instance
    do_reset();
    for (int b = 0; b < 5; b++) begin
      for (int k = 0; k < 4; k++) send(16'(b * 4 + k));
      tick();
      check($sformatf("wrap_cnt2_%0d", b), {30'h0, block_cnt2}, {30'h0, wrap_exp[b]});
      check($sformatf("wrap_cnt16_%0d", b), {16'h0, block_cnt}, 32'(b + 1));
    end

`ifdef SORT_COLLECT_FLUSH_EN
    // Partial block flushed with the arriving sample, then an empty flush
    do_reset();
    send(16'h0005);
    send(16'h0002);
    in_data = 16'h0007;
    in_valid = 1'b1;
    in_flush = 1'b1;
    tick();
    in_valid = 1'b0;
    in_flush = 1'b0;
    check("flush_valid", {31'h0, out_valid}, 32'd1);
    check_block("flush", 16'h0005, 16'h0002, 16'h0007, 16'hFFFF);
    check("flush_count", {29'h0, out_count}, 32'd3);
    tick();
    check("flush_drained", {31'h0, out_valid}, 32'd0);
    in_flush = 1'b1;
    tick();
    in_flush = 1'b0;
    check("empty_flush_valid", {31'h0, out_valid}, 32'd0);
    check("empty_flush_cnt", {16'h0, block_cnt}, 32'd1);
    for (int k = 0; k < 4; k++) send(16'(k + 1));
    check("full_count", {29'h0, out_count}, 32'd4);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1);
  end

endmodule
